// File: rtl/sc_regbackg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sc_regbackg_pkg : shared state and shift-selection encodings               |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package sc_regbackg_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweepState_t;

  localparam logic [1:0] SH_HOLD  = 2'b00;
  localparam logic [1:0] SH_LEFT  = 2'b01;
  localparam logic [1:0] SH_RIGHT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/sc_regbackg_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sc_regbackg_prescaler : wrapping shift-tick counter with sync clear/hold   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module sc_regbackg_prescaler #(
  parameter int PERIOD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_hold,
  output logic o_tick
);

  localparam int              C_CNTW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [C_CNTW-1:0] C_LAST = C_CNTW'(PERIOD - 1);

  logic [C_CNTW-1:0] r_count;

  assign o_tick = (r_count == C_LAST);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (!i_hold) begin
      r_count <= o_tick ? '0 : r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sc_regbackg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sc_regbackg_bank : masked rotate/shift background register bank with       |
// | reload sweep. Macro SC_REGBACKGBANK_FILL_EN selects logical fill shifts.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module sc_regbackg_bank
  import sc_regbackg_pkg::*;
#(
  parameter int REGBACKG_DATAWIDTH   = 8,
  parameter int REGBACKG_ROWS        = 4,
  parameter int REGBACKG_ADDRWIDTH   = 2,
  parameter int REGBACKG_SHIFTPERIOD = 1,
  parameter logic [REGBACKG_ROWS*REGBACKG_DATAWIDTH-1:0] DATA_FIXED_INITREGBACKG = '0
) (
  input  logic                                          SC_RegBACKGBANK_CLOCK_50,
  input  logic                                          SC_RegBACKGBANK_RESET_InHigh,
  input  logic                                          SC_RegBACKGBANK_clear_InLow,
  input  logic                                          SC_RegBACKGBANK_transition_In,
  input  logic                                          SC_RegBACKGBANK_load_InLow,
  input  logic [REGBACKG_ADDRWIDTH-1:0]                 SC_RegBACKGBANK_addr_In,
  input  logic [REGBACKG_DATAWIDTH-1:0]                 SC_RegBACKGBANK_data_InBUS,
  input  logic [1:0]                                    SC_RegBACKGBANK_shiftselection_In,
  input  logic [REGBACKG_ROWS-1:0]                      SC_RegBACKGBANK_rowmask_In,
  input  logic                                          SC_RegBACKGBANK_fill_In,
  output logic [REGBACKG_ROWS*REGBACKG_DATAWIDTH-1:0]   SC_RegBACKGBANK_data_OutBUS,
  output logic                                          SC_RegBACKGBANK_busy_Out,
  output logic                                          SC_RegBACKGBANK_done_Out
);

  localparam int                          C_W        = REGBACKG_DATAWIDTH;
  localparam logic [REGBACKG_ADDRWIDTH-1:0] C_LASTROW = REGBACKG_ADDRWIDTH'(REGBACKG_ROWS - 1);

  sweepState_t                   r_state;
  logic [REGBACKG_ADDRWIDTH-1:0] r_idx;
  logic                          r_busy;
  logic                          r_done;
  logic                          w_clearReq;
  logic                          w_startSweep;
  logic                          w_tick;

  assign w_clearReq   = ~SC_RegBACKGBANK_clear_InLow;
  assign w_startSweep = SC_RegBACKGBANK_transition_In & SC_RegBACKGBANK_clear_InLow;

  // Counter runs only while idle; a sweep start re-phases it to zero.
  sc_regbackg_prescaler #(
    .PERIOD (REGBACKG_SHIFTPERIOD)
  ) u_prescaler (
    .clk    (SC_RegBACKGBANK_CLOCK_50),
    .rst    (SC_RegBACKGBANK_RESET_InHigh),
    .i_clr  (w_startSweep),
    .i_hold (r_state == ST_SWEEP),
    .o_tick (w_tick)
  );

  always_ff @(posedge SC_RegBACKGBANK_CLOCK_50) begin
    if (SC_RegBACKGBANK_RESET_InHigh) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_clearReq) begin
        r_state <= ST_IDLE;
        r_idx   <= '0;
        r_busy  <= 1'b0;
      end else if (SC_RegBACKGBANK_transition_In) begin
        r_state <= ST_SWEEP;
        r_idx   <= '0;
        r_busy  <= 1'b1;
      end else if (r_state == ST_SWEEP) begin
        if (r_idx == C_LASTROW) begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign SC_RegBACKGBANK_busy_Out = r_busy;
  assign SC_RegBACKGBANK_done_Out = r_done;

`ifndef SC_REGBACKGBANK_FILL_EN
  logic w_unusedFill;
  assign w_unusedFill = SC_RegBACKGBANK_fill_In;
`endif

  for (genvar gRow = 0; gRow < REGBACKG_ROWS; gRow++) begin : g_row
    localparam logic [C_W-1:0]                C_INITROW = DATA_FIXED_INITREGBACKG[gRow*C_W +: C_W];
    localparam logic [REGBACKG_ADDRWIDTH-1:0] C_ROWADDR = REGBACKG_ADDRWIDTH'(gRow);

    logic [C_W-1:0] r_row;
    logic [C_W-1:0] w_shifted;
    logic           w_inLeft;
    logic           w_inRight;

`ifdef SC_REGBACKGBANK_FILL_EN
    assign w_inLeft  = SC_RegBACKGBANK_fill_In;
    assign w_inRight = SC_RegBACKGBANK_fill_In;
`else
    assign w_inLeft  = r_row[C_W-1];
    assign w_inRight = r_row[0];
`endif

    always_comb begin
      w_shifted = r_row;
      case (SC_RegBACKGBANK_shiftselection_In)
        SH_LEFT:  w_shifted = {r_row[C_W-2:0], w_inLeft};
        SH_RIGHT: w_shifted = {w_inRight, r_row[C_W-1:1]};
        SH_HOLD:  w_shifted = r_row;
        default:  w_shifted = r_row;
      endcase
    end

    always_ff @(posedge SC_RegBACKGBANK_CLOCK_50) begin
      if (SC_RegBACKGBANK_RESET_InHigh) begin
        r_row <= '0;
      end else if (w_clearReq) begin
        r_row <= C_INITROW;
      end else if (SC_RegBACKGBANK_transition_In) begin
        r_row <= r_row;
      end else if (r_state == ST_SWEEP) begin
        if (r_idx == C_ROWADDR) begin
          r_row <= C_INITROW;
        end
      end else if (!SC_RegBACKGBANK_load_InLow && (SC_RegBACKGBANK_addr_In == C_ROWADDR)) begin
        r_row <= SC_RegBACKGBANK_data_InBUS;
      end else if (w_tick && SC_RegBACKGBANK_rowmask_In[gRow]) begin
        r_row <= w_shifted;
      end
    end

    assign SC_RegBACKGBANK_data_OutBUS[gRow*C_W +: C_W] = r_row;
  end

endmodule
`default_nettype wire

// File: tb/tb_sc_regbackg_bank.sv
`default_nettype none
// Bench for sc_regbackg_bank: two instances (shift period 1 and 3) driven by
// shared stimulus and checked every cycle against a behavioural model.
module tb_sc_regbackg_bank;

  localparam logic [31:0] INIT = 32'h18244281;

  logic        clk;
  logic        rst;
  logic        clearN;
  logic        trans;
  logic        loadN;
  logic [2:0]  addr;
  logic [7:0]  data;
  logic [1:0]  sel;
  logic [3:0]  mask;
  logic        fill;

  logic [31:0] dataA, dataB;
  logic        busyA, busyB, doneA, doneB;

  int checks = 0;
  int errors = 0;
  bit modelValid = 1'b0;

  logic [7:0] mRows [2][4];
  int         mPos   [2];
  int         mPhase [2];
  bit         mBusy  [2];
  bit         mDone  [2];

  sc_regbackg_bank #(
    .REGBACKG_DATAWIDTH(8), .REGBACKG_ROWS(4), .REGBACKG_ADDRWIDTH(3),
    .REGBACKG_SHIFTPERIOD(1), .DATA_FIXED_INITREGBACKG(INIT)
  ) dutA (
    .SC_RegBACKGBANK_CLOCK_50(clk), .SC_RegBACKGBANK_RESET_InHigh(rst),
    .SC_RegBACKGBANK_clear_InLow(clearN), .SC_RegBACKGBANK_transition_In(trans),
    .SC_RegBACKGBANK_load_InLow(loadN), .SC_RegBACKGBANK_addr_In(addr),
    .SC_RegBACKGBANK_data_InBUS(data), .SC_RegBACKGBANK_shiftselection_In(sel),
    .SC_RegBACKGBANK_rowmask_In(mask), .SC_RegBACKGBANK_fill_In(fill),
    .SC_RegBACKGBANK_data_OutBUS(dataA), .SC_RegBACKGBANK_busy_Out(busyA),
    .SC_RegBACKGBANK_done_Out(doneA)
  );

  sc_regbackg_bank #(
    .REGBACKG_DATAWIDTH(8), .REGBACKG_ROWS(4), .REGBACKG_ADDRWIDTH(3),
    .REGBACKG_SHIFTPERIOD(3), .DATA_FIXED_INITREGBACKG(INIT)
  ) dutB (
    .SC_RegBACKGBANK_CLOCK_50(clk), .SC_RegBACKGBANK_RESET_InHigh(rst),
    .SC_RegBACKGBANK_clear_InLow(clearN), .SC_RegBACKGBANK_transition_In(trans),
    .SC_RegBACKGBANK_load_InLow(loadN), .SC_RegBACKGBANK_addr_In(addr),
    .SC_RegBACKGBANK_data_InBUS(data), .SC_RegBACKGBANK_shiftselection_In(sel),
    .SC_RegBACKGBANK_rowmask_In(mask), .SC_RegBACKGBANK_fill_In(fill),
    .SC_RegBACKGBANK_data_OutBUS(dataB), .SC_RegBACKGBANK_busy_Out(busyB),
    .SC_RegBACKGBANK_done_Out(doneB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] initRow(input int r);
    return 8'((INIT >> (8 * r)) & 32'hFF);
  endfunction

  // Rotation or fill shift expressed as plain arithmetic on the row value.
  function automatic logic [7:0] shiftRow(input logic [7:0] v, input bit left);
    int u;
    int inBit;
    u = int'(v);
`ifdef SC_REGBACKGBANK_FILL_EN
    inBit = int'(fill);
`else
    inBit = left ? (u / 128) : (u % 2);
`endif
    if (left) return 8'(((u * 2) % 256) + inBit);
    return 8'((u / 2) + inBit * 128);
  endfunction

  function automatic logic [31:0] packRows(input int k);
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < 4; r++) v = v | (32'(mRows[k][r]) << (8 * r));
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      bit wasSweep;
      bit tick;
      int per;
      per      = (k == 0) ? 1 : 3;
      wasSweep = (mPos[k] >= 0);
      tick     = !wasSweep && (mPhase[k] == per - 1);
      if (rst) begin
        for (int r = 0; r < 4; r++) mRows[k][r] = 8'h00;
        mPos[k] = -1; mPhase[k] = 0; mBusy[k] = 0; mDone[k] = 0;
      end else begin
        mDone[k] = 0;
        if (trans && clearN) mPhase[k] = 0;
        else if (!wasSweep) mPhase[k] = (mPhase[k] + 1) % per;
        if (!clearN) begin
          for (int r = 0; r < 4; r++) mRows[k][r] = initRow(r);
          mPos[k] = -1; mBusy[k] = 0;
        end else if (trans) begin
          mPos[k] = 0; mBusy[k] = 1;
        end else if (wasSweep) begin
          mRows[k][mPos[k]] = initRow(mPos[k]);
          mPos[k]++;
          if (mPos[k] == 4) begin
            mPos[k] = -1; mBusy[k] = 0; mDone[k] = 1;
          end
        end else begin
          for (int r = 0; r < 4; r++) begin
            if (!loadN && int'(addr) == r) mRows[k][r] = data;
            else if (tick && mask[r] && (sel == 2'd1 || sel == 2'd2))
              mRows[k][r] = shiftRow(mRows[k][r], sel == 2'd1);
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    modelStep();
    modelValid = 1'b1;
    @(negedge clk);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (modelValid) begin
      check("dataA", dataA, packRows(0));
      check("busyA", 32'(busyA), 32'(mBusy[0]));
      check("doneA", 32'(doneA), 32'(mDone[0]));
      check("dataB", dataB, packRows(1));
      check("busyB", 32'(busyB), 32'(mBusy[1]));
      check("doneB", 32'(doneB), 32'(mDone[1]));
    end
  end

  initial begin
    logic [31:0] exp;
    rst = 1; clearN = 1; trans = 0; loadN = 1; addr = 0; data = 0;
    sel = 0; mask = 0; fill = 1;
    cyc(); cyc();
    check("lit_reset_data", dataA, 32'h0);
    check("lit_reset_busy", 32'(busyA), 32'h0);
    check("lit_reset_done", 32'(doneA), 32'h0);

    rst = 0; clearN = 0; cyc(); clearN = 1;
    check("lit_clear_init", dataA, 32'h18244281);

    loadN = 0; addr = 3'd2; data = 8'hA5; cyc();
    check("lit_load_row2", 32'(dataA[23:16]), 32'hA5);
    addr = 3'd4; data = 8'h3C; cyc(); loadN = 1;
    check("lit_load_oob", dataA, 32'h18A54281);

    mask = 4'b0001; sel = 2'b01; cyc();
    check("lit_rot_left", dataA, 32'h18A54203);
    sel = 2'b10; cyc();
    check("lit_rot_right", dataA, 32'h18A54281);
    sel = 2'b00; mask = 4'b0000;

    loadN = 0; data = 8'hFF;
    for (int a = 0; a < 4; a++) begin addr = 3'(a); cyc(); end
    check("lit_all_ff", dataA, 32'hFFFFFFFF);

    trans = 1; addr = 3'd1; data = 8'h00; cyc(); trans = 0;
    check("lit_sweep_busy0", 32'(busyA), 32'h1);
    check("lit_sweep_data0", dataA, 32'hFFFFFFFF);
    for (int i = 0; i < 4; i++) begin
      cyc();
      exp = '0;
      for (int r = 0; r < 4; r++)
        exp = exp | (32'((r <= i) ? initRow(r) : 8'hFF) << (8 * r));
      check("lit_sweep_rows", dataA, exp);
      check("lit_sweep_busy", 32'(busyA), 32'(i < 3));
      check("lit_sweep_done", 32'(doneA), 32'(i == 3));
    end

    loadN = 1; mask = 4'b0001; sel = 2'b01;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("lit_presc_b", 32'(dataB[7:0]), (i < 2) ? 32'h81 : 32'h03);
      if (i == 0) check("lit_done_once", 32'(doneA), 32'h0);
    end
    sel = 2'b00; mask = 4'b0000;

    trans = 1; cyc(); trans = 0; cyc(); cyc();
    trans = 1; cyc(); trans = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("lit_restart_busy", 32'(busyA), 32'(i < 3));
      check("lit_restart_done", 32'(doneA), 32'(i == 3));
    end

    loadN = 0; addr = 3'd0; data = 8'h00; cyc(); loadN = 1;
    trans = 1; cyc(); trans = 0; cyc();
    clearN = 0; cyc(); clearN = 1;
    check("lit_abort_busy", 32'(busyA), 32'h0);
    check("lit_abort_data", dataA, 32'h18244281);
    cyc();
    check("lit_abort_nodone", 32'(doneA), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 63) == 0);
      clearN = ($urandom_range(0, 19) != 0);
      trans  = ($urandom_range(0, 24) == 0);
      loadN  = ($urandom_range(0, 2) != 0);
      addr   = 3'($urandom_range(0, 7));
      data   = 8'($urandom);
      sel    = 2'($urandom_range(0, 3));
      mask   = 4'($urandom_range(0, 15));
      fill   = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
